axis_pkt_master: RTL and testbench

AXIS_PKT_MASTER -- requirements
Module: axis_pkt_master

---
 rtl/axis_master_pkg.sv | 14 +
 rtl/axis_sync_fifo.sv | 53 +++++
 rtl/axis_pkt_master.sv | 86 ++++++++
 tb/tb_axis_pkt_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_master_pkg.sv
// axis_master_pkg: shared FSM state type and width helpers for the AXI4-Stream packet master.
package axis_master_pkg;

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word fall-through synchronous FIFO; full/empty derived from the count register.
module axis_sync_fifo
    import axis_master_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [cnt_w(DEPTH)-1:0]  o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // A push is refused while full even if a pop happens in the same cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/axis_pkt_master.sv
// axis_pkt_master: buffers core writes and emits them as fixed-length AXI4-Stream packets.
module axis_pkt_master
    import axis_master_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    parameter int MAX_PKT_LEN          = 256
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESETN,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     pi_mlp_data,
    input  logic                                pi_write_to_fifo,
    output logic                                po_wr_fifo_done,
    input  logic [len_w(MAX_PKT_LEN)-1:0]       pi_pkt_len,
    output logic                                po_fifo_full,
    output logic [cnt_w(FIFO_DEPTH)-1:0]        po_fifo_count,
    output logic                                po_pkt_done,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY
);

    localparam int LW = len_w(MAX_PKT_LEN);

    state_t        r_state;
    state_t        w_next;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_beat;
    logic [LW-1:0] w_len;
    logic          r_done;
    logic          r_pkt_done;
    logic          w_accept;
    logic          w_xfer;
    logic          w_empty;

    // The done cycle blocks re-acceptance of a request that is still held high.
    assign w_accept        = pi_write_to_fifo && !po_fifo_full && !r_done;
    assign w_xfer          = M_AXIS_TVALID && M_AXIS_TREADY;
    assign po_wr_fifo_done = r_done;
    assign po_pkt_done     = r_pkt_done;
    assign M_AXIS_TSTRB    = '1;

    axis_sync_fifo #(
        .WIDTH (C_M_AXIS_TDATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (M_AXIS_ACLK),
        .i_rst_n (M_AXIS_ARESETN),
        .i_push  (w_accept),
        .i_pop   (w_xfer),
        .i_din   (pi_mlp_data),
        .o_dout  (M_AXIS_TDATA),
        .o_count (po_fifo_count),
        .o_full  (po_fifo_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next        = r_state;
        w_len         = (pi_pkt_len == '0) ? LW'(1) :
                        (pi_pkt_len > LW'(MAX_PKT_LEN)) ? LW'(MAX_PKT_LEN) : pi_pkt_len;
        M_AXIS_TVALID = (r_state == STREAM) && !w_empty;
        M_AXIS_TLAST  = M_AXIS_TVALID && (r_beat == r_len - LW'(1));
        if (r_state == IDLE && !w_empty) w_next = STREAM;
        if (r_state == STREAM && w_xfer && M_AXIS_TLAST) w_next = IDLE;
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_state    <= IDLE;
            r_len      <= LW'(1);
            r_beat     <= '0;
            r_done     <= 1'b0;
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_len      <= (r_state == IDLE) ? w_len : r_len;
            r_beat     <= (r_state == IDLE) ? '0 : w_xfer ? r_beat + LW'(1) : r_beat;
            r_done     <= w_accept;
            r_pkt_done <= w_xfer && M_AXIS_TLAST;
        end
    end

endmodule

// File: tb/tb_axis_pkt_master.sv
// tb_axis_pkt_master: directed scoreboard bench for axis_pkt_master with per-beat TLAST model.
module tb_axis_pkt_master;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int MAXL  = 8;
    localparam int LW    = $clog2(MAXL + 1);
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr = 1'b0;
    logic          tready = 1'b0;
    logic [DW-1:0] din = '0;
    logic [LW-1:0] plen = '0;
    logic          done, full, pkt_done, tvalid, tlast;
    logic [DW-1:0] tdata;
    logic [DW/8-1:0] tstrb;
    logic [CW-1:0] cnt;

    int            n_asrt = 0;
    int            n_fail = 0;
    int            n_xfer = 0;
    int            mlen = 1;
    int            mbeat = 0;
    logic [DW-1:0] sb[$];
    logic          pd_exp = 1'b0;
    logic          stall = 1'b0;
    logic          e_last;
    logic [DW-1:0] s_data;
    logic          s_last;

    always #5 clk = ~clk;

    axis_pkt_master #(
        .C_M_AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH           (DEPTH),
        .MAX_PKT_LEN          (MAXL)
    ) dut (
        .M_AXIS_ACLK      (clk),
        .M_AXIS_ARESETN   (rst_n),
        .pi_mlp_data      (din),
        .pi_write_to_fifo (wr),
        .po_wr_fifo_done  (done),
        .pi_pkt_len       (plen),
        .po_fifo_full     (full),
        .po_fifo_count    (cnt),
        .po_pkt_done      (pkt_done),
        .M_AXIS_TVALID    (tvalid),
        .M_AXIS_TDATA     (tdata),
        .M_AXIS_TSTRB     (tstrb),
        .M_AXIS_TLAST     (tlast),
        .M_AXIS_TREADY    (tready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge, judges the beat that the next rising edge transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pkt_done", pkt_done, pd_exp);
            if (stall) begin
                chk("stall_valid", tvalid, 1);
                chk("stall_data", tdata, s_data);
                chk("stall_last", tlast, s_last);
            end
            pd_exp = 1'b0;
            if (tvalid && tready) begin
                chk("sb_nonempty", sb.size() == 0, 0);
                if (sb.size() != 0) begin
                    e_last = (mbeat == mlen - 1);
                    chk("tdata", tdata, sb.pop_front());
                    chk("tlast", tlast, e_last);
                    chk("tstrb", tstrb, 4'hF);
                    mbeat  = e_last ? 0 : mbeat + 1;
                    pd_exp = e_last;
                end
                n_xfer++;
            end
            stall  = tvalid && !tready;
            s_data = tdata;
            s_last = tlast;
        end
    end

    task automatic write_word(input logic [DW-1:0] d, input bit hold = 0);
        bit got = 0;
        wr = 1'b1;
        din = d;
        sb.push_back(d);
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk);
            #1;
            got = done;
        end
        chk("wr_done_seen", got, 1);
        if (hold) begin
            @(posedge clk);
            #1;
        end
        wr = 1'b0;
    endtask

    task automatic drain();
        tready = 1'b1;
        for (int k = 0; k < 300 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("drain_idle_valid", tvalid, 0);
        chk("drain_count", cnt, 0);
    endtask

    task automatic clear_model();
        sb.delete();
        mbeat  = 0;
        pd_exp = 1'b0;
        stall  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", tvalid, 0);
        chk("rst_last", tlast, 0);
        chk("rst_done", done, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_full", full, 0);
        chk("rst_count", cnt, 0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 4-beat packet, plus IDLE write-to-TVALID latency.
        plen = 4; mlen = 4; tready = 1'b0;
        write_word(32'hA0);
        chk("lat_idle_1", tvalid, 0);
        @(posedge clk);
        #1;
        chk("lat_idle_2", tvalid, 1);
        chk("lat_data", tdata, 32'hA0);
        for (int i = 1; i < 4; i++) write_word(32'hA0 + i);
        drain();

        // Fill to full with TREADY low; the 17th request stalls until a pop frees room.
        plen = 1; mlen = 1; tready = 1'b0;
        for (int i = 0; i < 16; i++) write_word(32'hB0 + i);
        chk("full_flag", full, 1);
        chk("full_count", cnt, 16);
        wr = 1'b1; din = 32'hC0; sb.push_back(32'hC0);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("stalled_done", done, 0);
        end
        chk("stalled_count", cnt, 16);
        tready = 1'b1;
        @(posedge clk);
        #1;
        tready = 1'b0;
        chk("pop_edge_done", done, 0);
        chk("pop_edge_count", cnt, 15);
        @(posedge clk);
        #1;
        chk("room_accept_done", done, 1);
        chk("room_accept_count", cnt, 16);
        wr = 1'b0;
        drain();

        // Three 3-beat packets under random backpressure.
        plen = 3; mlen = 3; base = n_xfer;
        fork
            for (int i = 0; i < 9; i++) write_word(32'hD0 + i);
            for (int g = 0; g < 300 && n_xfer < base + 9; g++) begin
                tready = ~tready;
                repeat ($urandom_range(1, 10)) begin
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        chk("rand_beats", n_xfer - base, 9);

        // Zero length acts as one; oversize length clamps to MAXL.
        plen = 0; mlen = 1; tready = 1'b1;
        for (int i = 0; i < 3; i++) write_word(32'h10 + i);
        drain();
        plen = LW'(MAXL + 5); mlen = MAXL; tready = 1'b1;
        for (int i = 0; i < MAXL; i++) write_word(32'h20 + i);
        drain();

        // Reset after beat 2 of a 4-beat packet.
        plen = 4; mlen = 4; tready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(32'hE0 + i);
        base = n_xfer;
        tready = 1'b1;
        for (int g = 0; g < 50 && n_xfer < base + 2; g++) begin
            @(posedge clk);
            #1;
        end
        tready = 1'b0;
        chk("pre_rst_beats", n_xfer - base, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", tvalid, 0);
        chk("arst_last", tlast, 0);
        chk("arst_count", cnt, 0);
        chk("arst_full", full, 0);
        chk("arst_done", done, 0);
        chk("arst_pkt_done", pkt_done, 0);
        clear_model();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_count", cnt, 0);
        for (int i = 0; i < 4; i++) write_word(32'hF0 + i);
        drain();

        // Request held across the done cycle writes exactly one entry.
        plen = 1; mlen = 1; tready = 1'b0;
        write_word(32'h55, 1);
        chk("hold_done_low", done, 0);
        chk("hold_count_1", cnt, 1);
        write_word(32'h66, 1);
        chk("hold_count_2", cnt, 2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
